// File: rtl/push_down_stack_pkg.sv
// Shared defaults and operation encoding for the push-down stack.
package push_down_stack_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_ADDR_W = 4;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage : push_down_stack_pkg

// File: rtl/stack_ram.sv
// Single-port synchronous RAM with a registered, load-enabled read port.
module stack_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds between reads so it can serve directly as the popped-word output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : stack_ram

// File: rtl/push_down_stack.sv
// Byte-wide LIFO: stack pointer, full/empty guards and popped-word output over stack_ram.
module push_down_stack
    import push_down_stack_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              PushPop,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]   sp_q;
    logic [ADDR_W:0]   sp_d;
    logic [ADDR_W:0]   sp_dec;
    logic              push_ok;
    logic              pop_ok;
    logic [ADDR_W-1:0] ram_addr;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_FULL);
    assign push_ok = En && (PushPop == OP_PUSH) && !full;
    assign pop_ok  = En && (PushPop == OP_POP)  && !empty;
    assign sp_dec  = sp_q - 1'b1;

    always_comb begin
        sp_d     = sp_q;
        ram_addr = sp_q[ADDR_W-1:0];
        if (push_ok) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_ok) begin
            sp_d     = sp_dec;
            ram_addr = sp_dec[ADDR_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clk),
        .rst   (Rst),
        .we    (push_ok && !Rst),
        .re    (pop_ok && !Rst),
        .addr  (ram_addr),
        .wdata (data_i),
        .rdata (data_o)
    );

endmodule : push_down_stack

// File: tb/tb_push_down_stack.sv
// Directed vector bench for push_down_stack: table of single-cycle steps plus fill/drain and reset sequences.
module tb_push_down_stack;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       En = 1'b0;
    logic       PushPop = 1'b0;
    logic [7:0] data_i = '0;
    logic [7:0] data_o;
    logic       empty;
    logic       full;

    int checks = 0;
    int failures = 0;

    push_down_stack #(
        .DATA_W (8),
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .En      (En),
        .PushPop (PushPop),
        .data_i  (data_i),
        .data_o  (data_o),
        .empty   (empty),
        .full    (full)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       pp;
        logic [7:0] din;
        logic [7:0] exp_d;
        logic       exp_e;
        logic       exp_f;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic pp, input logic [7:0] din);
        Rst = rst;
        En = en;
        PushPop = pp;
        data_i = din;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        En = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic e, input logic f);
        check({tag, ".data_o"}, data_o, d);
        check({tag, ".empty"}, {7'd0, empty}, {7'd0, e});
        check({tag, ".full"}, {7'd0, full}, {7'd0, f});
    endtask

    vec_t vecs [10];

    initial begin
        //            rst   en    pp    din   exp_d exp_e exp_f
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'd115, 8'd0,   1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd123, 8'd0,   1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'd77,  8'd0,   1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd200, 8'd0,   1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'd0,   8'd123, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'd55,  8'd123, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'd0,   8'd115, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 8'd0,   8'd115, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 8'd9,   8'd115, 1'b1, 1'b0};

        @(posedge Clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].pp, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_f);
        end

        // Fill to full; full must only rise on the 16th push.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            check_all($sformatf("fill%0d", i), 8'd115, 1'b0, (i == 15));
        end
        step(1'b0, 1'b1, 1'b0, 8'd99);
        check_all("push_full", 8'd115, 1'b0, 1'b1);

        // Drain: LIFO order, and entry 0 must not have been overwritten by the ignored push.
        for (int i = 15; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b1, 8'd0);
            check_all($sformatf("drain%0d", i), 8'(i), (i == 0), 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 8'd0);
        check_all("pop_empty2", 8'd0, 1'b1, 1'b0);

        // Reset mid-sequence discards entries and clears data_o.
        step(1'b0, 1'b1, 1'b0, 8'd11);
        step(1'b0, 1'b1, 1'b0, 8'd22);
        step(1'b0, 1'b1, 1'b1, 8'd0);
        check_all("pre_rst_pop", 8'd22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'd33);
        step(1'b0, 1'b1, 1'b0, 8'd44);
        check_all("pre_rst", 8'd22, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'd0);
        check_all("mid_rst", 8'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'd0);
        check_all("pop_after_rst", 8'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_push_down_stack

// File: doc/push_down_stack.md
Name: push_down_stack

Overview:
- Synchronous LIFO (push-down stack) of byte-wide words, backed by a small single-port RAM.
- One control pair: En qualifies an operation; PushPop selects push (0) or pop (1).
- Popped word is presented on a registered output.
- empty and full flags report occupancy to the surrounding control logic.

Parameters:
- DATA_W, 8, width of each stored word and of data_i/data_o.
- DEPTH, 16, number of stack entries (power of two).
- ADDR_W, 4, log2(DEPTH), RAM address width.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- En  input  1  operation enable; no state change when 0.
- PushPop  input  1  operation select: 0 = push, 1 = pop (sampled only when En=1).
- data_i  input  DATA_W  word to push.
- data_o  output  DATA_W  last popped word (registered).
- empty  output  1  high when stack holds 0 entries.
- full  output  1  high when stack holds DEPTH entries.

Behaviour:
- State: stack pointer sp, range 0..DEPTH, ADDR_W+1 bits, count of valid entries.
  - Entry sp-1 is the top of stack.
  - RAM array is DEPTH x DATA_W.
- empty = (sp == 0); full = (sp == DEPTH); both combinational from sp.
- Reset (Rst=1 at rising edge): sp <= 0; data_o <= 0.
  - empty=1, full=0 after the edge.
  - RAM contents are not cleared (don't-care).
  - Rst has priority over En/PushPop.
- Push (En=1, PushPop=0, full=0): at the edge, RAM[sp] <= data_i; sp <= sp+1. data_o unchanged.
- Pop (En=1, PushPop=1, empty=0): at the edge, data_o <= RAM[sp-1]; sp <= sp-1.
  - New data_o is visible immediately after that edge (one-edge latency).
  - Popped location is not erased.
- Push when full: ignored; sp, RAM and data_o unchanged; full stays 1.
- Pop when empty: ignored; sp unchanged; data_o holds its previous value; empty stays 1.
- En=0: no change regardless of PushPop/data_i.
- Only one operation per cycle; simultaneous push and pop is impossible by encoding.
- Reset mid-sequence discards all entries; the next pop after reset is ignored (empty).
- No wrap-around: sp saturates at the bounds via the full/empty guards above.

Decomposition:
- Shared package: DATA_W/DEPTH/ADDR_W defaults; constants OP_PUSH=1'b0, OP_POP=1'b1.
- One sub-module: stack_ram.
  - Single-port synchronous RAM, DEPTH x DATA_W.
  - Inputs: we, addr, wdata; output: registered rdata.
- Top holds sp, guard logic, flags and the data_o path.
- Read address on pop = sp-1.
- data_o loads from stack_ram rdata, with rdata registered on the pop edge.

Test Plan:
- Reset: Rst=1 for one edge -> data_o=0, empty=1, full=0.
- Push/pop order: push 115, push 123 (En=1, PushPop=0), then one pop:
  - after the pushes: empty=0;
  - after the pop edge: data_o=123;
  - second pop: data_o=115, empty=1.
- Idle/hold: En=0 cycles between operations with data_i changing -> sp, flags and data_o unchanged.
- Pop when empty: after the above, third pop -> data_o stays 115, empty=1.
- Fill to full: push 0..15 -> full=1 after 16th push; 17th push (value 99) ignored. Then 16 pops yield 15 down to 0, and empty=1 at end.
- Reset mid-operation: push 3 words, assert Rst -> empty=1; subsequent pop leaves data_o=0.
